// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-port ALU sharing controller: opcode values,
// controller states and the reserved-opcode check.
package alu_share_ctrl_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // Reserved opcodes still go to the ALU; they are only flagged on the response.
    function automatic logic is_reserved_op(input logic [2:0] op);
        return !(op inside {OP_ADD, OP_AND, OP_OR, OP_SUB, OP_MUL, OP_SLT});
    endfunction

endpackage

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one registered ALU between two requesters:
// one operation in flight, operands held on the ALU until the response retires.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zflag,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,

    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant;
    logic             accept;
    logic             retire;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next = state;
        grant      = 1'b0;
        accept     = 1'b0;
        retire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept = 1'b1;
                    // On a tie the requester that did not win last time goes first.
                    if (req0_valid && req1_valid) begin
                        grant = ~last_grant;
                    end else begin
                        grant = req1_valid;
                    end
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is held low while reset is asserted even though the state is already IDLE.
    assign req0_ready = rst_n && accept && !grant;
    assign req1_ready = rst_n && accept &&  grant;

    assign sel_a  = grant ? req1_a  : req0_a;
    assign sel_b  = grant ? req1_b  : req0_b;
    assign sel_op = grant ? req1_op : req0_op;

    assign rsp_data = alu_res;
    assign rsp_zero = alu_zflag;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OP_ADD;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            last_grant <= 1'b1;
            op_count   <= '0;
        end else begin
            rsp_valid <= (state_next == RESP);
            busy      <= (state_next != IDLE);
            if (accept) begin
                alu_a      <= sel_a;
                alu_b      <= sel_b;
                alu_op     <= sel_op;
                rsp_id     <= grant;
                rsp_err    <= is_reserved_op(sel_op);
                last_grant <= grant;
            end
            if (retire) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: the driver pushes expected responses at
// accept time, an independent monitor pops and compares them on retirement.
module tb_alu_share_ctrl;

    localparam int WIDTH = 32;
    // A narrow counter lets the wrap to zero be reached in a short run.
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    logic [2:0]       alu_op;
    logic             alu_zflag;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
    logic [WIDTH-1:0] rsp_data;
    logic [CNT_W-1:0] op_count;

    alu_share_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_zflag(alu_zflag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   outstanding = 1'b0;
    bit   last_grant = 1'b1;
    int   model_count = 0;
    int   accept_cyc = 0;
    bit   first_seen = 1'b0;
    int   rsp_mode = 0;
    bit   acc0 = 1'b0;
    bit   acc1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a - b;
            3'd4: return a * b;
            3'd7: return (a < b) ? WIDTH'(1) : '0;
            default: return '0;
        endcase
    endfunction

    // Registered ALU fixture standing in for the parent-level ALU instance.
    always_ff @(posedge clk) begin
        alu_res   <= ref_alu(alu_a, alu_b, alu_op);
        alu_zflag <= (ref_alu(alu_a, alu_b, alu_op) == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [2:0] op);
        exp_t e;
        e.id   = id;
        e.data = ref_alu(a, b, op);
        e.zero = (e.data == '0);
        e.err  = (op == 3'b101) || (op == 3'b110);
        sb.push_back(e);
        outstanding = 1'b1;
        last_grant  = id;
        accept_cyc  = cyc;
        first_seen  = 1'b0;
    endtask

    // Called at a falling edge with inputs settled; samples just before the rising edge.
    task automatic tick();
        logic e0, e1;
        #3;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (rst_n) begin
            e0 = !outstanding && req0_valid && (!req1_valid || last_grant);
            e1 = !outstanding && req1_valid && (!req0_valid || !last_grant);
            check("req0_ready", req0_ready, e0);
            check("req1_ready", req1_ready, e1);
            if (e0) begin
                acc0 = 1'b1;
                push_exp(1'b0, req0_a, req0_b, req0_op);
            end else if (e1) begin
                acc1 = 1'b1;
                push_exp(1'b1, req1_a, req1_b, req1_op);
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && outstanding; i++) tick();
        check("drain_timeout", outstanding, 0);
        #2;
        check("busy_idle", busy, 0);
        @(negedge clk);
    endtask

    task automatic issue(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op);
        bit got = 1'b0;
        if (!id) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = id ? acc1 : acc0;
        end
        check("accept_timeout", got, 1);
        if (!id) req0_valid = 1'b0;
        else     req1_valid = 1'b0;
    endtask

    task automatic run_pair();
        bit d0 = 1'b0;
        bit d1 = 1'b0;
        for (int i = 0; i < 40 && !(d0 && d1); i++) begin
            tick();
            if (acc0) begin d0 = 1'b1; req0_valid = 1'b0; end
            if (acc1) begin d1 = 1'b1; req1_valid = 1'b0; end
        end
        check("pair_accept", d0 && d1, 1);
        wait_idle();
    endtask

    function automatic logic [WIDTH-1:0] rnd_operand();
        return ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 7)) : WIDTH'($urandom());
    endfunction

    // Monitor: acts as the response consumer and retires expected entries.
    initial begin
        exp_t e;
        rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
            #4;
            if (rst_n) begin
                check("op_count", op_count, model_count);
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        check("rsp_valid_unexpected", rsp_valid, 0);
                    end else begin
                        e = sb[0];
                        if (!first_seen) begin
                            check("rsp_latency", cyc - accept_cyc, 2);
                            first_seen = 1'b1;
                        end
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_zero", rsp_zero, e.zero);
                        check("rsp_err", rsp_err, e.err);
                        check("busy_resp", busy, 1);
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            outstanding = 1'b0;
                            model_count = (model_count + 1) % (1 << CNT_W);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = 3'd0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = 3'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_err", rsp_err, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        // First tie after reset goes to requester 0, then requester 1, then 0 again.
        req0_valid = 1'b1; req0_a = 32'd9;    req0_b = 32'd9;    req0_op = 3'b011;
        req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = 3'b001;
        run_pair();
        req0_valid = 1'b1; req0_a = 32'd1;    req0_b = 32'd1;    req0_op = 3'b000;
        req1_valid = 1'b1; req1_a = 32'd3;    req1_b = 32'd4;    req1_op = 3'b010;
        run_pair();

        issue(1'b0, 32'd5, 32'd7, 3'b000);
        wait_idle();

        // Back-pressure: response held, competing request not accepted meanwhile.
        rsp_mode = 1;
        issue(1'b0, 32'h1_0000, 32'h1_0000, 3'b100);
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd3; req1_op = 3'b000;
        repeat (10) tick();
        rsp_mode = 0;
        for (int i = 0; i < 20 && !acc1; i++) tick();
        check("bp_release_accept", acc1, 1);
        req1_valid = 1'b0;
        wait_idle();

        issue(1'b0, 32'd1, 32'd2, 3'b101);
        wait_idle();
        issue(1'b1, 32'd3, 32'd4, 3'b111);
        wait_idle();

        // Reset while a response is pending and requester 1 is waiting.
        rsp_mode = 1;
        issue(1'b0, 32'd5, 32'd6, 3'b000);
        tick();
        tick();
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_op = 3'b000;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_op_count", op_count, 0);
        check("midrst_req1_ready", req1_ready, 0);
        sb.delete();
        outstanding = 1'b0;
        model_count = 0;
        last_grant  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_mode = 0;
        acc1 = 1'b0;
        for (int i = 0; i < 10 && !acc1; i++) tick();
        check("post_rst_accept", acc1, 1);
        req1_valid = 1'b0;
        wait_idle();

        // Randomized traffic, long enough to wrap the completion counter.
        rsp_mode = 2;
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            if (acc0) begin
                req0_valid = 1'b0;
            end else if (!req0_valid) begin
                if ($urandom_range(0, 1) == 1) begin
                    req0_valid = 1'b1; req0_a = rnd_operand(); req0_b = rnd_operand();
                    req0_op = 3'($urandom_range(0, 7));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0;
            end
            if (acc1) begin
                req1_valid = 1'b0;
            end else if (!req1_valid) begin
                if ($urandom_range(0, 1) == 1) begin
                    req1_valid = 1'b1; req1_a = rnd_operand(); req1_b = rnd_operand();
                    req1_op = 3'($urandom_range(0, 7));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0;
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_mode = 0;
        wait_idle();
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-port round-robin controller that shares the single registered 32-bit ALU (AluB: A, B, 3-bit op, one-cycle registered Res and Zflag) between two requesters. It accepts one operation at a time over a valid/ready handshake, holds the operands on the ALU inputs, and returns result, zero flag, requester ID and an illegal-op flag over a valid/ready response channel. It sits between the issue logic and the ALU instance in the datapath.

## Interface
- WIDTH, 32: operand/result width; must match the ALU.
- CNT_W, 16: width of completed-operation counter.

- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_op / req1_op  in  3  ALU opcode.
- alu_a, alu_b  out  WIDTH  registered operands to ALU.
- alu_op  out  3  registered opcode to ALU.
- alu_res  in  WIDTH  ALU registered result.
- alu_zflag  in  1  ALU registered zero flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that issued the operation.
- rsp_data  out  WIDTH  result (alu_res passthrough while in RESP).
- rsp_zero  out  1  zero flag (alu_zflag passthrough).
- rsp_err  out  1  opcode was 101 or 110 (reserved).
- busy  out  1  state != IDLE.
- op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W.

## Operation
- Legal opcodes: 000 add, 001 and, 010 or, 011 sub, 100 mul (low WIDTH bits), 111 unsigned set-less-than. 101/110 are still issued (ALU returns 0, zero=1) but rsp_err=1.
- States: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant by round-robin; reqN_ready=1 combinationally for granted N only; at edge latch a/b/op into alu_a/alu_b/alu_op, grant into rsp_id, err into rsp_err; -> EXEC. No valid: stay.
- Arbitration: only one valid -> grant it. Both valid -> grant the requester not in last_grant; last_grant updates on accept.
- EXEC: one cycle, ALU registers result from held operands; -> RESP.
- RESP: rsp_valid=1; operands held stable so alu_res/alu_zflag stay valid. On rsp_valid && rsp_ready: op_count+1, -> IDLE. Else hold all outputs.
- reqN_ready is 0 in EXEC and RESP; no accept in the cycle a response retires.
- Requesters must hold valid and payload until ready; dropping valid before ready is legal and cancels the request with no effect.
- Reset (any time, including mid EXEC/RESP): in-flight operation discarded, no response.
- Reset values: state IDLE, alu_a=0, alu_b=0, alu_op=000, rsp_id=0, rsp_err=0, rsp_valid=0, busy=0, op_count=0, last_grant=1 (requester 0 wins first tie), req ready=0 until reset released.

## Timing
- Accept at edge E0; EXEC cycle between E0 and E1; ALU updates Res at E1; rsp_valid high from after E1.
- Minimum turnaround: 3 cycles per operation (IDLE, EXEC, RESP with rsp_ready=1).
- rsp_data/rsp_zero valid only while rsp_valid=1.
- op_count increments at the retiring edge; 2^CNT_W−1 wraps to 0.
- All outputs except reqN_ready, rsp_data, rsp_zero are registered.

## Structure
- Shared package: opcode constants (OP_ADD, OP_AND, OP_OR, OP_SUB, OP_MUL, OP_SLT), reserved-opcode check function, state enum for IDLE/EXEC/RESP.
- Single module; ALU instantiated at the parent level, not inside. Round-robin grant logic is small and kept inline; no sub-module.

## Test plan
- Req0 only: a=5, b=7, op=000, rsp_ready=1 -> req0_ready at E0, rsp_valid after E1, rsp_data=12, rsp_zero=0, rsp_id=0, op_count=1.
- Both valid from reset: req0 sub 9−9, req1 and F0&0F -> req0 served first (rsp_data=0, zero=1, id=0), then req1 (data=0, zero=1, id=1); third tie goes to req0.
- Back-pressure: rsp_ready=0 for 10 cycles on mul 0x10000×0x10000 -> rsp_valid held, rsp_data=0 stable, zero=1, no new accept; releases on rsp_ready.
- Reserved op 101 with a=1, b=2 -> rsp_err=1, rsp_data=0, rsp_zero=1; next op 111 (3<4) -> rsp_err=0, rsp_data=1.
- RST_N low during RESP -> rsp_valid=0, busy=0 immediately, op_count=0; pending requester re-accepted after release.
- Force op_count to 0xFFFF via 65535 ops (or preload in sim) -> next retire gives 0x0000.
